// File: rtl/dmem_lsu_port_pkg.sv
// Shared encodings, captured-request payload and the host memory model
// reached through paddr_read/paddr_write by every memory-facing module.
package dmem_lsu_port_pkg;

  // Access size encodings on req_size_i
  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_RSV = 2'd3;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Latency counter width (latency range 1..15)
  localparam int unsigned CNT_W = 4;

  // Control part of an accepted request
  typedef struct packed {
    logic       wen;
    logic [1:0] size;
    logic       fault;
  } req_ctl_t;

  // Byte length of an access; the reserved size is faulted separately
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Sparse byte-addressed physical memory and call counters
  logic [7:0]  pmem [longint unsigned];
  int unsigned pmem_rd_calls;
  int unsigned pmem_wr_calls;

  // Read len bytes little-endian; bytes never written read as zero
  function automatic longint unsigned paddr_read(input longint unsigned addr,
                                                 input int unsigned     len);
    longint unsigned v;
    v = 64'd0;
    for (int unsigned i = 0; i < len && i < 8; i++) begin
      if (pmem.exists(addr + 64'(i))) begin
        v = v | (64'(pmem[addr + 64'(i)]) << (8 * i));
      end
    end
    pmem_rd_calls = pmem_rd_calls + 1;
    return v;
  endfunction

  // Write the low len bytes of data little-endian
  function automatic void paddr_write(input longint unsigned addr,
                                      input int unsigned     len,
                                      input longint unsigned data);
    for (int unsigned i = 0; i < len && i < 8; i++) begin
      pmem[addr + 64'(i)] = 8'(data >> (8 * i));
    end
    pmem_wr_calls = pmem_wr_calls + 1;
  endfunction

endpackage

// File: rtl/dmem_lsu_port_chk.sv
// Combinational access check: size decode, alignment and window range.
module dmem_chk
  import dmem_lsu_port_pkg::*;
#(
  parameter int unsigned    AW       = 32,
  parameter logic [AW-1:0]  MEM_BASE = AW'(32'h8000_0000),
  parameter logic [AW-1:0]  MEM_SIZE = AW'(32'h0800_0000)
) (
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    size_i,
  output logic          fault_c_o
);

  localparam int unsigned AW1 = AW + 1;

  logic [2:0]   len_c;
  logic         misalign_c;
  logic         below_c;
  logic         above_c;
  logic [AW:0]  end_c;
  logic [AW:0]  lim_c;

  // Fault decode; range end computed one bit wider so the top of the space cannot wrap
  always_comb begin
    len_c      = size_to_len(size_i);
    misalign_c = 1'b0;
    case (size_i)
      SZ_H:    misalign_c = addr_i[0];
      SZ_W:    misalign_c = |addr_i[1:0];
      default: misalign_c = 1'b0;
    endcase
    below_c   = (addr_i < MEM_BASE);
    end_c     = {1'b0, addr_i} + AW1'(len_c);
    lim_c     = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    above_c   = (end_c > lim_c);
    fault_c_o = (size_i == SZ_RSV) | misalign_c | below_c | above_c;
  end

endmodule

// File: rtl/dmem_lsu_port.sv
// Data-side memory responder: one handshaked load/store at a time with a
// fixed access latency; faulting requests never reach memory.
module dmem_lsu_port
  import dmem_lsu_port_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  MEM_BASE    = ADDR_WIDTH'(32'h8000_0000),
  parameter logic [ADDR_WIDTH-1:0]  MEM_SIZE    = ADDR_WIDTH'(32'h0800_0000),
  parameter int unsigned            MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wen_i,
  input  logic [1:0]            req_size_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  cap_c;
  logic                  access_c;
  logic                  resp_done_c;
  logic                  req_fault_c;
  logic [63:0]           mask_c;

  req_ctl_t              ctl_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  dmem_chk #(
    .AW       (ADDR_WIDTH),
    .MEM_BASE (MEM_BASE),
    .MEM_SIZE (MEM_SIZE)
  ) u_chk (
    .addr_i    (req_addr_i),
    .size_i    (req_size_i),
    .fault_c_o (req_fault_c)
  );

  // Next state: accept in IDLE, count down in WAIT, hold the response in RESP
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_c       = 1'b0;
    access_c    = 1'b0;
    resp_done_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          cap_c   = 1'b1;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access_c = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          resp_done_c = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  // State, counter and handshake output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Capture the accepted request together with its fault verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (cap_c) begin
      ctl_q   <= '{wen: req_wen_i, size: req_size_i, fault: req_fault_c};
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Load result mask from the captured size
  always_comb begin
    case (ctl_q.size)
      SZ_B:    mask_c = 64'h0000_0000_0000_00FF;
      SZ_H:    mask_c = 64'h0000_0000_0000_FFFF;
      default: mask_c = 64'h0000_0000_FFFF_FFFF;
    endcase
  end

  // Memory access on the last latency edge; reset wins over a pending access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access_c) begin
      if (ctl_q.fault) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (ctl_q.wen) begin
        paddr_write(64'(addr_q), 32'(size_to_len(ctl_q.size)), 64'(wdata_q) & mask_c);
        rdata_q <= '0;
        err_q   <= 1'b0;
      end else begin
        rdata_q <= DATA_WIDTH'(paddr_read(64'(addr_q), 32'(size_to_len(ctl_q.size))) & mask_c);
        err_q   <= 1'b0;
      end
    end else if (resp_done_c) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_lsu_port.sv
// Scoreboard bench for dmem_lsu_port: directed cases plus random traffic
// against a byte-array memory model.
module tb_dmem_lsu_port;
  import dmem_lsu_port_pkg::*;

  localparam int unsigned     LAT  = 2;
  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned SIZE = 64'h0800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_wen_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic [31:0] req_addr_i = 32'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int unsigned exp_rd = 0;
  int unsigned exp_wr = 0;
  logic [7:0]  mdl [longint unsigned];
  bit          rr_rand = 1'b0;
  bit          rr_val = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_lsu_port #(
    .MEM_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_wen_i    (req_wen_i),
    .req_size_i   (req_size_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: fault rules and memory effect from plain byte arithmetic
  function automatic exp_t model(input bit wen, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    longint unsigned ad;
    longint unsigned len;
    ad = 64'(a);
    len = (sz == 2'd0) ? 64'd1 : (sz == 2'd1) ? 64'd2 : 64'd4;
    e.rdata = 32'd0;
    e.due = 0;
    e.err = (sz == 2'd3) || (ad % len != 0) || (ad < BASE) || (ad + len > BASE + SIZE);
    if (!e.err) begin
      if (wen) begin
        for (int i = 0; i < int'(len); i++) mdl[ad + 64'(i)] = 8'(wd >> (8 * i));
        exp_wr++;
      end else begin
        for (int i = 0; i < int'(len); i++)
          if (mdl.exists(ad + 64'(i)))
            e.rdata = e.rdata | (32'(mdl[ad + 64'(i)]) << (8 * i));
        exp_rd++;
      end
    end
    return e;
  endfunction

  task automatic issue(input bit wen, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_wen_i   = wen;
    req_size_i  = sz;
    req_addr_i  = a;
    req_wdata_i = wd;
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      chk("accept_timeout", 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b0;
      return;
    end
    e = model(wen, sz, a, wd);
    e.due = cyc + 1 + int'(LAT);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || resp_valid_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || resp_valid_o)
      chk("drain_timeout", 64'(q.size()) + 64'(resp_valid_o), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_valid"}, 64'(resp_valid_o), 64'd0);
    chk({tag, "_rdata"}, 64'(resp_rdata_o), 64'd0);
    chk({tag, "_err"}, 64'(resp_err_o), 64'd0);
  endtask

  // Sole driver of resp_ready_i, updated just after each rising edge
  initial begin : rr_drv
    forever begin
      @(posedge clk);
      #1;
      resp_ready_i = rr_rand ? (($urandom % 4) != 0) : rr_val;
    end
  end

  // Monitor: pops and compares whenever a response is presented
  initial begin : mon
    bit pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid_o) begin
        if (q.size() == 0) begin
          chk("spurious_resp", 64'(resp_valid_o), 64'd0);
        end else begin
          if (!pv) chk("resp_latency", 64'(cyc), 64'(q[0].due));
          chk("resp_rdata", 64'(resp_rdata_o), 64'(q[0].rdata));
          chk("resp_err", 64'(resp_err_o), 64'(q[0].err));
          chk("ready_in_resp", 64'(req_ready_o), 64'd0);
          if (resp_ready_i) void'(q.pop_front());
        end
      end
      pv = rst_n && resp_valid_o;
    end
  end

  initial begin : main
    int          n;
    int unsigned wr0;
    int unsigned rd0;
    exp_t        e;
    logic [31:0] a;
    logic [1:0]  sz;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Word store then word load
    wr0 = pmem_wr_calls;
    issue(1'b1, SZ_W, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, SZ_W, 32'h8000_0010, 32'h0, 1'b0);
    drain();
    chk("one_write", 64'(pmem_wr_calls - wr0), 64'd1);

    // Byte store then half load merging it
    issue(1'b1, SZ_B, 32'h8000_0011, 32'h0000_00AA, 1'b0);
    issue(1'b0, SZ_H, 32'h8000_0010, 32'h0, 1'b0);
    drain();

    // Misaligned and below-base: no memory call
    wr0 = pmem_wr_calls;
    rd0 = pmem_rd_calls;
    issue(1'b0, SZ_H, 32'h8000_0011, 32'h0, 1'b0);
    issue(1'b0, SZ_W, 32'h7FFF_FFFC, 32'h0, 1'b0);
    issue(1'b1, SZ_RSV, 32'h8000_0000, 32'h1234_5678, 1'b0);
    issue(1'b0, SZ_W, 32'h8800_0000, 32'h0, 1'b0);
    issue(1'b0, SZ_W, 32'hFFFF_FFFC, 32'h0, 1'b0);
    drain();
    chk("fault_no_call", 64'(pmem_wr_calls - wr0) + 64'(pmem_rd_calls - rd0), 64'd0);

    // Window edge: last word and last byte are legal
    issue(1'b1, SZ_W, 32'h87FF_FFFC, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, SZ_B, 32'h87FF_FFFF, 32'h0, 1'b0);
    drain();

    // Response held with request valid held high
    rd0 = pmem_rd_calls;
    rr_val = 1'b0;
    issue(1'b0, SZ_W, 32'h8000_0010, 32'h0, 1'b1);
    n = 0;
    while (!resp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", 64'(resp_valid_o), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid_o), 64'd1);
      chk("hold_ready", 64'(req_ready_o), 64'd0);
    end
    chk("hold_one_read", 64'(pmem_rd_calls - rd0), 64'd1);
    rr_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_hs", 64'(req_ready_o), 64'd1);
    e = model(1'b0, SZ_W, 32'h8000_0010, 32'h0);
    e.due = cyc + 1 + int'(LAT);
    q.push_back(e);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    chk("accepted_next", 64'(req_ready_o), 64'd0);
    drain();
    chk("two_reads", 64'(pmem_rd_calls - rd0), 64'd2);

    // Reset during WAIT aborts a store
    issue(1'b1, SZ_W, 32'h8000_0020, 32'h1122_3344, 1'b0);
    drain();
    wr0 = pmem_wr_calls;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_wen_i   = 1'b1;
    req_size_i  = SZ_W;
    req_addr_i  = 32'h8000_0020;
    req_wdata_i = 32'h5566_7788;
    chk("abort_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("abort");
    chk("abort_no_write", 64'(pmem_wr_calls - wr0), 64'd0);
    issue(1'b0, SZ_W, 32'h8000_0020, 32'h0, 1'b0);
    drain();

    // Random traffic with random response back-pressure
    rr_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      case ($urandom % 8)
        0:       a = 32'h7FFF_FFF0 + ($urandom % 32);
        1:       a = 32'h87FF_FFF0 + ($urandom % 32);
        2:       a = 32'hFFFF_FFFC + ($urandom % 4);
        default: a = 32'h8000_0000 + ($urandom % 64);
      endcase
      sz = 2'($urandom);
      issue(1'($urandom), sz, a, $urandom, 1'b0);
    end
    rr_rand = 1'b0;
    drain();
    chk("total_writes", 64'(pmem_wr_calls), 64'(exp_wr));
    chk("total_reads", 64'(pmem_rd_calls), 64'(exp_rd));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
